// File: rtl/life_pkg.sv
// ============================================================================
// Module : life_pkg
// Desc   : Shared grid defaults, stepper FSM states and B3/S23 rule helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package life_pkg;

  localparam int LIFE_ROWS   = 4;
  localparam int LIFE_COLS   = 16;
  localparam int LIFE_ADDR_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam logic [3:0] BIRTH      = 4'd3;
  localparam logic [3:0] SURVIVE_LO = 4'd2;
  localparam logic [3:0] SURVIVE_HI = 4'd3;

  function automatic logic next_cell(input logic alive_i, input logic [3:0] count_i);
    if (alive_i) begin
      return (count_i >= SURVIVE_LO) && (count_i <= SURVIVE_HI);
    end
    return count_i == BIRTH;
  endfunction

endpackage

`default_nettype wire

// File: rtl/life_row_next.sv
// ============================================================================
// Module : life_row_next
// Desc   : Combinational next-generation row from above/current/below rows.
//          LIFE_STEPPER_WRAP_EN selects toroidal columns; otherwise edges dead.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module life_row_next
  import life_pkg::*;
#(
  parameter int COLS = LIFE_COLS
) (
  input  logic [COLS-1:0] above_i,
  input  logic [COLS-1:0] cur_i,
  input  logic [COLS-1:0] below_i,
  output logic [COLS-1:0] next_o
);

  // Index 0 holds column -1, index COLS+1 holds column COLS.
  logic [COLS+1:0] above_x;
  logic [COLS+1:0] cur_x;
  logic [COLS+1:0] below_x;

`ifdef LIFE_STEPPER_WRAP_EN
  assign above_x = {above_i[0], above_i, above_i[COLS-1]};
  assign cur_x   = {cur_i[0],   cur_i,   cur_i[COLS-1]};
  assign below_x = {below_i[0], below_i, below_i[COLS-1]};
`else
  assign above_x = {1'b0, above_i, 1'b0};
  assign cur_x   = {1'b0, cur_i,   1'b0};
  assign below_x = {1'b0, below_i, 1'b0};
`endif

  generate
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [3:0] nbr;
      assign nbr = 4'(above_x[c]) + 4'(above_x[c+1]) + 4'(above_x[c+2])
                 + 4'(cur_x[c])                      + 4'(cur_x[c+2])
                 + 4'(below_x[c]) + 4'(below_x[c+1]) + 4'(below_x[c+2]);
      assign next_o[c] = next_cell(cur_i[c], nbr);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/life_stepper.sv
// ============================================================================
// Module : life_stepper
// Desc   : Reads the grid through the selector port, computes one B3/S23
//          generation and writes it back. Macro LIFE_STEPPER_WRAP_EN = torus.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module life_stepper
  import life_pkg::*;
#(
  parameter int ROWS   = LIFE_ROWS,
  parameter int COLS   = LIFE_COLS,
  parameter int ADDR_W = LIFE_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [15:0]       gen_count,
  output logic [ADDR_W-1:0] array_selector,
  output logic              write_enb,
  output logic [COLS-1:0]   alive_in_selector,
  input  logic [COLS-1:0]   alive_out_selector
);

  localparam int                CNT_W        = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  LOAD_LAST    = CNT_W'(ROWS);
  localparam logic [CNT_W-1:0]  ROW_LAST_CNT = CNT_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] ROW_LAST     = ADDR_W'(ROWS - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       gen_count_q;
  logic [COLS-1:0]   shadow_q [ROWS];
  logic [COLS-1:0]   next_q   [ROWS];

  logic [ADDR_W-1:0] row;
  logic [CNT_W-1:0]  cnt_m1;
  logic [ADDR_W-1:0] load_idx;
  logic [COLS-1:0]   above_row, cur_row, below_row, next_row;

  assign row      = cnt_q[ADDR_W-1:0];
  assign cnt_m1   = cnt_q - CNT_W'(1);
  assign load_idx = cnt_m1[ADDR_W-1:0];
  assign cur_row  = shadow_q[row];

`ifdef LIFE_STEPPER_WRAP_EN
  assign above_row = shadow_q[(row == '0) ? ROW_LAST : row - 1'b1];
  assign below_row = shadow_q[(row == ROW_LAST) ? '0 : row + 1'b1];
`else
  assign above_row = (row == '0)       ? '0 : shadow_q[row - 1'b1];
  assign below_row = (row == ROW_LAST) ? '0 : shadow_q[row + 1'b1];
`endif

  life_row_next #(
    .COLS (COLS)
  ) u_row_next (
    .above_i (above_row),
    .cur_i   (cur_row),
    .below_i (below_row),
    .next_o  (next_row)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      gen_count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == ST_DONE) begin
        gen_count_q <= gen_count_q + 16'd1;
      end
    end
  end

  // Read data lags the address by one cycle, so LOAD cycle r captures row r-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROWS; i++) begin
        shadow_q[i] <= '0;
        next_q[i]   <= '0;
      end
    end else begin
      if (state_q == ST_LOAD && cnt_q != '0) begin
        shadow_q[load_idx] <= alive_out_selector;
      end
      if (state_q == ST_COMPUTE) begin
        next_q[row] <= next_row;
      end
    end
  end

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    busy              = 1'b0;
    done              = 1'b0;
    write_enb         = 1'b0;
    array_selector    = '0;
    alive_in_selector = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        busy           = 1'b1;
        array_selector = row;
        if (cnt_q == LOAD_LAST) begin
          state_d = ST_COMPUTE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_COMPUTE: begin
        busy = 1'b1;
        if (cnt_q == ROW_LAST_CNT) begin
          state_d = ST_WRITE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WRITE: begin
        busy              = 1'b1;
        write_enb         = 1'b1;
        array_selector    = row;
        alive_in_selector = next_q[row];
        if (cnt_q == ROW_LAST_CNT) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign gen_count = gen_count_q;

endmodule

`default_nettype wire

// File: tb/tb_life_stepper.sv
// ============================================================================
// Module : tb_life_stepper
// Desc   : Directed bench for life_stepper with a synchronous-read grid memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_life_stepper;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, write_enb;
  logic [15:0] gen_count;
  logic [1:0]  array_selector;
  logic [15:0] alive_in_selector;
  logic [15:0] alive_out_selector;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] mem     [4];
  logic [15:0] preload [4];
  logic        preload_go = 1'b0;
  logic [1:0]  wr_log [$];

  always #5 clk = ~clk;

  life_stepper dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .busy               (busy),
    .done               (done),
    .gen_count          (gen_count),
    .array_selector     (array_selector),
    .write_enb          (write_enb),
    .alive_in_selector  (alive_in_selector),
    .alive_out_selector (alive_out_selector)
  );

  // Grid memory: registered read, write on strobe, bulk preload port.
  always @(posedge clk) begin
    alive_out_selector <= mem[array_selector];
    if (preload_go) begin
      for (int i = 0; i < 4; i++) mem[i] <= preload[i];
    end else if (write_enb) begin
      mem[array_selector] <= alive_in_selector;
      wr_log.push_back(array_selector);
    end
  end

  task automatic load_grid(input logic [15:0] r0, r1, r2, r3);
    preload[0] = r0; preload[1] = r1; preload[2] = r2; preload[3] = r3;
    preload_go = 1'b1;
    @(posedge clk); #1;
    preload_go = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Start one step; done_cyc counts cycles from the start edge (first = 1).
  task automatic do_step(output int done_cyc, output int busy_cyc, output logic done_after);
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    done_cyc = 1;
    busy_cyc = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && done_cyc < 40) begin
      @(posedge clk); #1;
      done_cyc++;
      if (busy === 1'b1) busy_cyc++;
    end
    @(posedge clk); #1;
    done_after = done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done); end
    tests_run++; if (gen_count !== 16'h0) begin tests_failed++; $display("FAIL reset_gen: got %h expected 0000", gen_count); end
    tests_run++; if (write_enb !== 1'b0) begin tests_failed++; $display("FAIL reset_we: got %b expected 0", write_enb); end
    tests_run++; if (array_selector !== 2'd0) begin tests_failed++; $display("FAIL reset_sel: got %0d expected 0", array_selector); end
    tests_run++; if (alive_in_selector !== 16'h0) begin tests_failed++; $display("FAIL reset_wdata: got %h expected 0000", alive_in_selector); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_blinker();
    int dc, bc; logic da;
    logic [15:0] exp [4];
    exp = '{16'h0020, 16'h0020, 16'h0020, 16'h0000};
    load_grid(16'h0000, 16'h0070, 16'h0000, 16'h0000);
    do_step(dc, bc, da);
    tests_run++; if (dc != 14) begin tests_failed++; $display("FAIL blinker_done_cycle: got %0d expected 14", dc); end
    tests_run++; if (bc != 13) begin tests_failed++; $display("FAIL blinker_busy_cycles: got %0d expected 13", bc); end
    tests_run++; if (da !== 1'b0) begin tests_failed++; $display("FAIL blinker_done_width: got %b expected 0", da); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (mem[i] !== exp[i]) begin tests_failed++; $display("FAIL blinker_row%0d: got %h expected %h", i, mem[i], exp[i]); end
    end
    tests_run++; if (gen_count !== 16'd1) begin tests_failed++; $display("FAIL blinker_gen: got %0d expected 1", gen_count); end
  endtask

  task automatic test_block();
    int dc, bc; logic da;
    logic [15:0] exp [4];
    exp = '{16'h0003, 16'h0003, 16'h0000, 16'h0000};
    pulse_reset();
    load_grid(16'h0003, 16'h0003, 16'h0000, 16'h0000);
    for (int s = 0; s < 2; s++) begin
      do_step(dc, bc, da);
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (mem[i] !== exp[i]) begin tests_failed++; $display("FAIL block_step%0d_row%0d: got %h expected %h", s, i, mem[i], exp[i]); end
      end
    end
    tests_run++; if (gen_count !== 16'd2) begin tests_failed++; $display("FAIL block_gen: got %0d expected 2", gen_count); end
  endtask

  task automatic test_seam();
    int dc, bc; logic da;
    logic [15:0] exp [4];
`ifdef LIFE_STEPPER_WRAP_EN
    exp = '{16'h0001, 16'h0001, 16'h0001, 16'h0000};
`else
    exp = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
`endif
    pulse_reset();
    load_grid(16'h0000, 16'h8003, 16'h0000, 16'h0000);
    do_step(dc, bc, da);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (mem[i] !== exp[i]) begin tests_failed++; $display("FAIL seam_row%0d: got %h expected %h", i, mem[i], exp[i]); end
    end
  endtask

  task automatic test_empty();
    int dc, bc, base; logic da;
    logic [1:0] addr;
    load_grid(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    base = wr_log.size();
    do_step(dc, bc, da);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (mem[i] !== 16'h0000) begin tests_failed++; $display("FAIL empty_row%0d: got %h expected 0000", i, mem[i]); end
    end
    tests_run++;
    if (wr_log.size() - base != 4) begin
      tests_failed++; $display("FAIL empty_write_count: got %0d expected 4", wr_log.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        addr = wr_log[base + i];
        tests_run++;
        if (addr !== 2'(i)) begin tests_failed++; $display("FAIL empty_write_addr%0d: got %0d expected %0d", i, addr, i); end
      end
    end
  endtask

  task automatic test_start_ignored();
    int cyc, ndone;
    logic [15:0] g0;
    load_grid(16'h0000, 16'h0070, 16'h0000, 16'h0000);
    g0 = gen_count;
    ndone = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 36) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc >= 7 && cyc <= 9);
      if (done === 1'b1) ndone++;
    end
    start = 1'b0;
    tests_run++; if (ndone != 1) begin tests_failed++; $display("FAIL restart_done_count: got %0d expected 1", ndone); end
    tests_run++; if (gen_count !== g0 + 16'd1) begin tests_failed++; $display("FAIL restart_gen: got %0d expected %0d", gen_count, g0 + 16'd1); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL restart_idle: got busy=%b expected 0", busy); end
    tests_run++; if (mem[1] !== 16'h0020) begin tests_failed++; $display("FAIL restart_row1: got %h expected 0020", mem[1]); end
  endtask

  task automatic test_reset_midwrite();
    int cyc, dc, bc; logic da;
    load_grid(16'h0000, 16'h0070, 16'h0000, 16'h0000);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 11) begin
      @(posedge clk); #1;
      cyc++;
    end
    tests_run++;
    if (write_enb !== 1'b1 || array_selector !== 2'd1) begin
      tests_failed++; $display("FAIL midwrite_second_write: got we=%b sel=%0d expected we=1 sel=1", write_enb, array_selector);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (write_enb !== 1'b0) begin tests_failed++; $display("FAIL midrst_we: got %b expected 0", write_enb); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    tests_run++; if (gen_count !== 16'h0) begin tests_failed++; $display("FAIL midrst_gen: got %0d expected 0", gen_count); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL midrst_done: got %b expected 0", done); end
    tests_run++; if (array_selector !== 2'd0) begin tests_failed++; $display("FAIL midrst_sel: got %0d expected 0", array_selector); end
    rst = 1'b0;
    load_grid(16'h0000, 16'h0070, 16'h0000, 16'h0000);
    do_step(dc, bc, da);
    tests_run++; if (dc != 14) begin tests_failed++; $display("FAIL after_rst_done_cycle: got %0d expected 14", dc); end
    tests_run++; if (gen_count !== 16'd1) begin tests_failed++; $display("FAIL after_rst_gen: got %0d expected 1", gen_count); end
    tests_run++; if (mem[0] !== 16'h0020 || mem[2] !== 16'h0020) begin
      tests_failed++; $display("FAIL after_rst_rows: got %h/%h expected 0020/0020", mem[0], mem[2]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_blinker();
    test_block();
    test_seam();
    test_empty();
    test_start_ignored();
    test_reset_midwrite();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/life_stepper.md
# life_stepper

Generation engine for the Conway grid memory. On a start pulse it reads every row of the grid through the memory's selector port, computes the next generation under rule B3/S23, and writes the new rows back through the same port. It is the writer/updater on the selector side of `Block_Mem`; the VGA read side is untouched.

## Interface
- `ROWS`, 4, grid rows, one memory word per row
- `COLS`, 16, cells per row, equal to memory word width; bit *c* is column *c*
- `ADDR_W`, 2, selector width, clog2(ROWS)
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request one generation step; sampled only in IDLE
- `busy`  out  1  high in LOAD, COMPUTE and WRITE
- `done`  out  1  one-cycle pulse when write-back completes
- `gen_count`  out  16  generations completed since reset; wraps 0xFFFF→0
- `array_selector`  out  ADDR_W  row address to memory
- `write_enb`  out  1  memory write strobe
- `alive_in_selector`  out  COLS  row data written to memory
- `alive_out_selector`  in  COLS  row data read from memory; valid one cycle after address

## Operation
- FSM states: IDLE → LOAD → COMPUTE → WRITE → DONE → IDLE.
- IDLE: `start`=1 at an edge moves to LOAD, with row counter cleared.
- LOAD (ROWS+1 cycles): drives `array_selector`=0..ROWS-1 on successive cycles; captures `alive_out_selector` into shadow row r one cycle after address r.
- COMPUTE (ROWS cycles): cycle r produces next row r from shadow rows r-1, r, r+1 into a separate next-gen buffer. The shadow is never modified in place.
- Neighbour count is 4 bits (0..8). Live cell survives on 2 or 3. Dead cell is born on exactly 3.
- WRITE (ROWS cycles): `write_enb`=1, `array_selector`=r, `alive_in_selector`=next row r for r=0..ROWS-1.
- DONE (1 cycle): `done`=1, `busy`=0, `gen_count` increments.
- `start` outside IDLE is ignored and is not queued. `start` held high in IDLE/DONE-return begins a new step on the first IDLE cycle.
- Does not drive the memory's `debug`. The grid is preloaded externally before the first start.

## Timing
- Reset values: `busy`=0, `done`=0, `gen_count`=0, `write_enb`=0, `array_selector`=0, `alive_in_selector`=0; state IDLE. Shadow and next-gen buffers are cleared.
- `start` sampled at edge T0: `busy`=1 from the cycle after T0 for 3·ROWS+1 cycles (13 at default). `done` pulses in the following cycle, 3·ROWS+2 cycles after T0 (14).
- `write_enb` is low in every state except WRITE.
- Reset mid-operation:
  - Next cycle returns to IDLE with all outputs at reset values.
  - Rows already written stay written; the grid may be a mix of two generations. This is accepted.

## Configuration
- `LIFE_STEPPER_WRAP_EN` defined: toroidal grid. Row -1 maps to ROWS-1, row ROWS to 0, column -1 to COLS-1, column COLS to 0.
- Not defined: cells outside the grid count as dead. No wrap in either axis.

## Structure
- Package `life_pkg`:
  - ROWS, COLS, ADDR_W defaults
  - FSM state enum
  - rule constants: BIRTH=3, SURVIVE_LO=2, SURVIVE_HI=3
- Sub-module `life_row_next`: purely combinational. Inputs are the above, current and below rows; output is the next row. The edge-wrap choice is made here under the macro.
- Top level holds the FSM, counters and both row buffers.

## Test plan
- Horizontal blinker: rows {0x0000,0x0070,0x0000,0x0000}, pulse start → rows {0x0020,0x0020,0x0020,0x0000}; `done` at T0+14; `gen_count`=1.
- Block: rows {0x0003,0x0003,0,0}, two steps → unchanged after each; `gen_count`=2.
- Seam blinker {0,0x8003,0,0}:
  - With WRAP_EN → {0x0001,0x0001,0x0001,0}.
  - Without → all rows 0.
- Empty grid: all 0 → stays 0; exactly ROWS `write_enb` cycles, with addresses 0,1,2,3 in order.
- `start` re-pulsed during COMPUTE → ignored; one `done` only; `gen_count` +1.
- `rst` asserted in second WRITE cycle → next cycle `write_enb`=0, `busy`=0, `gen_count`=0; a new start completes normally.
